hcsr04_emulador: RTL

Synthesizable behavioural model of the HC-SR04 ultrasonic sensor, the responder side of the sonar's trigger/echo interface. It accepts the `trigger` pulse driven by the sonar and returns an `echo` pulse whose width encodes a programmable distance. It serves as the echo source in sonar system benches, and on the FPGA it replaces the physical sensor for closed-loop self-test.

---
 rtl/hcsr04_emulador.sv | 132 +++++++++++++
 1 files changed

// File: rtl/hcsr04_emulador.sv
// HC-SR04 ultrasonic sensor emulator: answers a trigger pulse with an echo
// pulse whose width encodes a programmable distance in centimetres.
module hcsr04_emulador #(
    parameter int CICLOS_US   = 50,
    parameter int TRIG_MIN_US = 10,
    parameter int ATRASO_US   = 200,
    parameter int US_POR_CM   = 58,
    parameter int DIST_MAX_CM = 400,
    parameter int TIMEOUT_US  = 38000,
    parameter int RECUPERA_US = 60000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       habilitar,
    input  logic       trigger,
    input  logic [8:0] distancia,
    output logic       echo,
    output logic       pronto,
    output logic       erro_trigger,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL   = 4'd0,
        ESPERA    = 4'd1,
        MEDE_TRIG = 4'd2,
        ATRASO    = 4'd3,
        ECHO      = 4'd4,
        RECUPERA  = 4'd5
    } estado_t;

    localparam int             PW        = (CICLOS_US > 1) ? $clog2(CICLOS_US) : 1;
    localparam logic [PW-1:0]  PRESC_MAX = PW'(CICLOS_US - 1);
    localparam logic [15:0]    TRIG_MIN  = 16'(TRIG_MIN_US);
    localparam logic [15:0]    ATRASO_N  = 16'(ATRASO_US);
    localparam logic [15:0]    US_CM     = 16'(US_POR_CM);
    localparam logic [8:0]     DIST_MAX  = 9'(DIST_MAX_CM);
    localparam logic [15:0]    TIMEOUT_N = 16'(TIMEOUT_US);
    localparam logic [15:0]    RECUP_N   = 16'(RECUPERA_US);

    estado_t       estado;
    estado_t       estado_prox;
    logic          trig_m;
    logic          trig_s;
    logic [PW-1:0] presc;
    logic [15:0]   cnt;
    logic [15:0]   cnt_prox;
    logic [8:0]    dist_r;
    logic [15:0]   largura;
    logic          tick_us;
    logic          sobe;
    logic          desce;
    logic          erro_prox;

    // Edges of trig_s are read from its input stage so the FSM changes state
    // on the very clock edge where trig_s itself changes.
    assign sobe  = trig_m & ~trig_s;
    assign desce = trig_s & ~trig_m;

    assign tick_us  = (presc == PRESC_MAX);
    // Count including the microsecond that completes on this edge; saturates.
    assign cnt_prox = (tick_us && cnt != 16'hFFFF) ? cnt + 16'd1 : cnt;

    assign largura = (dist_r == 9'd0 || dist_r > DIST_MAX)
                   ? TIMEOUT_N
                   : {7'd0, dist_r} * US_CM;

    assign db_estado = estado;

    // NOTE: every variable assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        estado_prox = estado;
        erro_prox   = 1'b0;
        if (!habilitar) begin
            estado_prox = ESPERA;
        end else begin
            case (estado)
                INICIAL:   estado_prox = ESPERA;
                ESPERA:    if (sobe) estado_prox = MEDE_TRIG;
                MEDE_TRIG: begin
                    if (desce) begin
                        if (cnt_prox >= TRIG_MIN) begin
                            estado_prox = ATRASO;
                        end else begin
                            estado_prox = ESPERA;
                            erro_prox   = 1'b1;
                        end
                    end
                end
                ATRASO:    if (cnt_prox >= ATRASO_N) estado_prox = ECHO;
                ECHO:      if (cnt_prox >= largura) estado_prox = RECUPERA;
                RECUPERA:  if (cnt_prox >= RECUP_N) estado_prox = sobe ? MEDE_TRIG : ESPERA;
                default:   estado_prox = INICIAL;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge, regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado       <= INICIAL;
            trig_m       <= 1'b0;
            trig_s       <= 1'b0;
            presc        <= '0;
            cnt          <= '0;
            dist_r       <= '0;
            echo         <= 1'b0;
            pronto       <= 1'b0;
            erro_trigger <= 1'b0;
        end else begin
            trig_m <= trigger;
            trig_s <= trig_m;
            estado <= estado_prox;
            if (estado_prox != estado) begin
                presc <= '0;
                cnt   <= '0;
            end else begin
                presc <= tick_us ? '0 : presc + PW'(1);
                cnt   <= cnt_prox;
            end
            if (estado == MEDE_TRIG && estado_prox == ATRASO) begin
                dist_r <= distancia;
            end
            echo         <= (estado_prox == ECHO);
            pronto       <= (estado == ECHO) && (estado_prox == RECUPERA);
            erro_trigger <= erro_prox;
        end
    end

endmodule
